if_id_stage: RTL and testbench

- IF/ID pipeline boundary of the 5-stage MIPS core, directly downstream of the PC/next-PC stage.
- Captures the fetch-stage PC and PC+4 and pairs them with the instruction word from a synchronous instruction memory. That memory has 1-cycle read latency and is addressed by the current PC.
- Handles stall (IFIDWrite=0) by holding an instruction skid copy, and handles flush (taken branch or jump resolved in EX/MEM) by inserting a NOP bubble.
- Keeps saturating stall and flush event counters for performance debug.

---
 rtl/if_id_stage.sv | 114 +++++++++++
 tb/tb_if_id_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the 5-stage MIPS core.
// Pairs the registered fetch PC with the 1-cycle-late imem read data, keeps a
// skid copy of the instruction across stalls, inserts NOP bubbles on flush and
// counts stall/flush cycles for performance debug.
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      IF_PC,
    input  logic [31:0]      IF_PCPlus4,
    input  logic [31:0]      imem_rdata,
    input  logic             IFIDWrite,
    input  logic             flush,
    output logic [31:0]      ID_PC,
    output logic [31:0]      ID_PCPlus4,
    output logic [31:0]      ID_instr,
    output logic             ID_valid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      id_pc_q, id_pc_d;
    logic [31:0]      id_pc4_q, id_pc4_d;
    logic             id_valid_q, id_valid_d;
    logic [31:0]      hold_instr_q, hold_instr_d;
    logic             hold_v_q, hold_v_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic stall_evt;
    assign stall_evt = !flush && !IFIDWrite;

    // Pipeline register next state: flush beats stall, stall beats advance.
    always_comb begin
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;
        id_valid_d   = id_valid_q;
        hold_instr_d = hold_instr_q;
        hold_v_d     = hold_v_q;
        if (flush) begin
            // PC fields are don't-care for a bubble; loading them aids debug.
            id_pc_d    = IF_PC;
            id_pc4_d   = IF_PCPlus4;
            id_valid_d = 1'b0;
            hold_v_d   = 1'b0;
        end else if (IFIDWrite) begin
            id_pc_d    = IF_PC;
            id_pc4_d   = IF_PCPlus4;
            id_valid_d = 1'b1;
            hold_v_d   = 1'b0;
        end else if (!hold_v_q) begin
            // imem will re-read the held IF_PC (the next instruction), so keep
            // the word that belongs to the instruction currently in ID.
            hold_instr_d = imem_rdata;
            hold_v_d     = 1'b1;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CntOne;
        end
        if (flush && (flush_cnt_q != CntMax)) begin
            flush_cnt_d = flush_cnt_q + CntOne;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_pc_q      <= 32'h0;
            id_pc4_q     <= 32'h0;
            id_valid_q   <= 1'b0;
            hold_instr_q <= 32'h0;
            hold_v_q     <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
            id_valid_q   <= id_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_v_q     <= hold_v_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Output mux: depends only on registers and imem_rdata.
    always_comb begin
        if (!id_valid_q) begin
            ID_instr = NOP_INSTR;
        end else if (hold_v_q) begin
            ID_instr = hold_instr_q;
        end else begin
            ID_instr = imem_rdata;
        end
    end

    assign ID_PC      = id_pc_q;
    assign ID_PCPlus4 = id_pc4_q;
    assign ID_valid   = id_valid_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage (instantiated with 4-bit counters).
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] IA  = 32'h2008_0001;
    localparam logic [31:0] IB  = 32'h2009_0002;
    localparam logic [31:0] IC  = 32'h0109_5020;
    localparam logic [31:0] ID  = 32'h1000_0003;
    localparam logic [31:0] IE  = 32'h8D2A_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic        wr;
        logic        fl;
        logic [31:0] rd;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic [3:0]  scnt;
        logic [3:0]  fcnt;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] IF_PC;
    logic [31:0] IF_PCPlus4;
    logic [31:0] imem_rdata;
    logic        IFIDWrite;
    logic        flush;
    logic [31:0] ID_PC;
    logic [31:0] ID_PCPlus4;
    logic [31:0] ID_instr;
    logic        ID_valid;
    logic [3:0]  stall_cnt;
    logic [3:0]  flush_cnt;

    int   n_cmp;
    int   n_fail;
    obs_t exp_q[$];

    if_id_stage #(
        .NOP_INSTR(NOP),
        .CNT_W    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .IF_PC     (IF_PC),
        .IF_PCPlus4(IF_PCPlus4),
        .imem_rdata(imem_rdata),
        .IFIDWrite (IFIDWrite),
        .flush     (flush),
        .ID_PC     (ID_PC),
        .ID_PCPlus4(ID_PCPlus4),
        .ID_instr  (ID_instr),
        .ID_valid  (ID_valid),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t observed();
        return {ID_PC, ID_PCPlus4, ID_instr, ID_valid, stall_cnt, flush_cnt};
    endfunction

    // Inputs change on the falling edge, away from the active edge.
    task automatic drive(input stim_t s);
        @(negedge clk);
        IF_PC      = s.pc;
        IF_PCPlus4 = s.pc + 32'd4;
        IFIDWrite  = s.wr;
        flush      = s.fl;
        imem_rdata = s.rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        IF_PC      = 32'h0;
        IF_PCPlus4 = 32'h4;
        IFIDWrite  = 1'b1;
        flush      = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e;
        @(negedge clk);
        rst_n      = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        e = '{32'h0, 32'h0, NOP, 1'b0, 4'd0, 4'd0};
        n_cmp++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h", observed(), e);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", observed(), e);
        end
    endtask

    task automatic test_straight();
        stim_t st [4] = '{
            '{32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF},
            '{32'h4, 1'b1, 1'b0, IA},
            '{32'h8, 1'b1, 1'b0, IB},
            '{32'hC, 1'b1, 1'b0, IC}};
        obs_t ex [3] = '{
            '{32'h0, 32'h4, IA, 1'b1, 4'd0, 4'd0},
            '{32'h4, 32'h8, IB, 1'b1, 4'd0, 4'd0},
            '{32'h8, 32'hC, IC, 1'b1, 4'd0, 4'd0}};
        obs_t e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(st[i]);
            #1;
            if (i > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (observed() !== e) begin
                    n_fail++;
                    $display("FAIL straight row %0d: got %h want %h", i, observed(), e);
                end
            end
            if (i < 3) exp_q.push_back(ex[i]);
        end
    endtask

    task automatic test_stall1();
        stim_t st [5] = '{
            '{32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF},
            '{32'h4, 1'b1, 1'b0, IA},
            '{32'h8, 1'b0, 1'b0, IB},
            '{32'h8, 1'b1, 1'b0, IC},
            '{32'hC, 1'b1, 1'b0, IC}};
        obs_t ex [4] = '{
            '{32'h0, 32'h4, IA, 1'b1, 4'd0, 4'd0},
            '{32'h4, 32'h8, IB, 1'b1, 4'd0, 4'd0},
            '{32'h4, 32'h8, IB, 1'b1, 4'd1, 4'd0},
            '{32'h8, 32'hC, IC, 1'b1, 4'd1, 4'd0}};
        obs_t e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(st[i]);
            #1;
            if (i > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (observed() !== e) begin
                    n_fail++;
                    $display("FAIL stall1 row %0d: got %h want %h", i, observed(), e);
                end
            end
            if (i < 4) exp_q.push_back(ex[i]);
        end
    endtask

    task automatic test_stall3();
        stim_t st [7] = '{
            '{32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF},
            '{32'h4, 1'b1, 1'b0, IA},
            '{32'h8, 1'b0, 1'b0, IB},
            '{32'h8, 1'b0, 1'b0, 32'h1111_1111},
            '{32'h8, 1'b0, 1'b0, 32'h2222_2222},
            '{32'h8, 1'b1, 1'b0, 32'h3333_3333},
            '{32'hC, 1'b1, 1'b0, IC}};
        obs_t ex [6] = '{
            '{32'h0, 32'h4, IA, 1'b1, 4'd0, 4'd0},
            '{32'h4, 32'h8, IB, 1'b1, 4'd0, 4'd0},
            '{32'h4, 32'h8, IB, 1'b1, 4'd1, 4'd0},
            '{32'h4, 32'h8, IB, 1'b1, 4'd2, 4'd0},
            '{32'h4, 32'h8, IB, 1'b1, 4'd3, 4'd0},
            '{32'h8, 32'hC, IC, 1'b1, 4'd3, 4'd0}};
        obs_t e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(st[i]);
            #1;
            if (i > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (observed() !== e) begin
                    n_fail++;
                    $display("FAIL stall3 row %0d: got %h want %h", i, observed(), e);
                end
            end
            if (i < 6) exp_q.push_back(ex[i]);
        end
    endtask

    task automatic test_flush();
        stim_t st [7] = '{
            '{32'h0,  1'b1, 1'b0, 32'hDEAD_BEEF},
            '{32'h4,  1'b1, 1'b0, IA},
            '{32'h8,  1'b1, 1'b0, IB},
            '{32'hC,  1'b1, 1'b0, IC},
            '{32'h10, 1'b1, 1'b1, ID},
            '{32'h40, 1'b1, 1'b0, 32'hBADB_AD00},
            '{32'h44, 1'b1, 1'b0, IE}};
        obs_t ex [6] = '{
            '{32'h0,  32'h4,  IA,  1'b1, 4'd0, 4'd0},
            '{32'h4,  32'h8,  IB,  1'b1, 4'd0, 4'd0},
            '{32'h8,  32'hC,  IC,  1'b1, 4'd0, 4'd0},
            '{32'hC,  32'h10, ID,  1'b1, 4'd0, 4'd0},
            '{32'h10, 32'h14, NOP, 1'b0, 4'd0, 4'd1},
            '{32'h40, 32'h44, IE,  1'b1, 4'd0, 4'd1}};
        obs_t e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(st[i]);
            #1;
            if (i > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (observed() !== e) begin
                    n_fail++;
                    $display("FAIL flush row %0d: got %h want %h", i, observed(), e);
                end
            end
            if (i < 6) exp_q.push_back(ex[i]);
        end
    endtask

    task automatic test_flush_stall();
        stim_t st [7] = '{
            '{32'h0,  1'b1, 1'b0, 32'hDEAD_BEEF},
            '{32'h4,  1'b1, 1'b0, IA},
            '{32'h8,  1'b0, 1'b0, IB},
            '{32'h8,  1'b0, 1'b1, 32'h4444_4444},
            '{32'h40, 1'b0, 1'b0, 32'h5555_5555},
            '{32'h40, 1'b1, 1'b0, 32'h6666_6666},
            '{32'h44, 1'b1, 1'b0, IE}};
        obs_t ex [6] = '{
            '{32'h0,  32'h4,  IA,  1'b1, 4'd0, 4'd0},
            '{32'h4,  32'h8,  IB,  1'b1, 4'd0, 4'd0},
            '{32'h4,  32'h8,  IB,  1'b1, 4'd1, 4'd0},
            '{32'h8,  32'hC,  NOP, 1'b0, 4'd1, 4'd1},
            '{32'h8,  32'hC,  NOP, 1'b0, 4'd2, 4'd1},
            '{32'h40, 32'h44, IE,  1'b1, 4'd2, 4'd1}};
        obs_t e;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(st[i]);
            #1;
            if (i > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (observed() !== e) begin
                    n_fail++;
                    $display("FAIL flush_stall row %0d: got %h want %h", i, observed(), e);
                end
            end
            if (i < 6) exp_q.push_back(ex[i]);
        end
    endtask

    task automatic test_reset_mid_stall();
        obs_t e;
        do_reset();
        drive('{32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF});
        drive('{32'h4, 1'b0, 1'b0, IA});
        drive('{32'h4, 1'b0, 1'b0, 32'h7777_7777});
        #2;
        e = '{32'h0, 32'h4, IA, 1'b1, 4'd1, 4'd0};
        n_cmp++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL pre_async_reset: got %h want %h", observed(), e);
        end
        // Assert reset between edges; outputs must clear without a clock.
        rst_n = 1'b0;
        #1;
        e = '{32'h0, 32'h0, NOP, 1'b0, 4'd0, 4'd0};
        n_cmp++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", observed(), e);
        end
        drive('{32'h20, 1'b1, 1'b0, 32'h7777_7777});
        rst_n = 1'b1;
        drive('{32'h24, 1'b1, 1'b0, 32'h1234_5678});
        #1;
        e = '{32'h20, 32'h24, 32'h1234_5678, 1'b1, 4'd0, 4'd0};
        n_cmp++;
        if (observed() !== e) begin
            n_fail++;
            $display("FAIL post_reset_advance: got %h want %h", observed(), e);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] want;
        do_reset();
        drive('{32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF});
        for (int i = 0; i < 20; i++) begin
            drive('{32'h4, 1'b0, 1'b0, IA});
            @(posedge clk);
            #1;
            want = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            n_cmp++;
            if (stall_cnt !== want || flush_cnt !== 4'd0) begin
                n_fail++;
                $display("FAIL stall_sat step %0d: got %0d/%0d want %0d/0",
                         i, stall_cnt, flush_cnt, want);
            end
        end
        for (int i = 0; i < 18; i++) begin
            drive('{32'h8, 1'b0, 1'b1, IB});
            @(posedge clk);
            #1;
            want = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            n_cmp++;
            if (flush_cnt !== want || stall_cnt !== 4'd15) begin
                n_fail++;
                $display("FAIL flush_sat step %0d: got %0d/%0d want %0d/15",
                         i, flush_cnt, stall_cnt, want);
            end
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        IF_PC      = 32'h0;
        IF_PCPlus4 = 32'h4;
        IFIDWrite  = 1'b1;
        flush      = 1'b0;
        imem_rdata = 32'h0;
        test_reset();
        test_straight();
        test_stall1();
        test_stall3();
        test_flush();
        test_flush_stall();
        test_reset_mid_stall();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
